// File: rtl/bram_4096.sv
// Single-port 4096 x 8 synchronous block RAM with a registered, enable-gated read
// port and a busy flag that masks port commands for a few edges after reset.
module bram_4096 #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 8,
   parameter int BUSY_CYCLES = 4
) (
   input  logic                  BRAM_PORTA_0_clk,
   input  logic                  BRAM_PORTA_0_rst,
   input  logic [ADDR_WIDTH-1:0] BRAM_PORTA_0_addr,
   input  logic [DATA_WIDTH-1:0] BRAM_PORTA_0_din,
   output logic [DATA_WIDTH-1:0] BRAM_PORTA_0_dout,
   input  logic                  BRAM_PORTA_0_en,
   input  logic                  BRAM_PORTA_0_we,
   output logic                  rsta_busy_0
);

   localparam int CNT_W = 3;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
   logic [CNT_W-1:0]      busy_cnt;
   logic                  accept;

   // Port commands only take effect on edges outside reset and the busy window.
   assign accept = !BRAM_PORTA_0_rst && (busy_cnt == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge BRAM_PORTA_0_clk) begin
      if (BRAM_PORTA_0_rst) begin
         busy_cnt          <= CNT_W'(BUSY_CYCLES);
         rsta_busy_0       <= 1'b1;
         BRAM_PORTA_0_dout <= '0;
      end else if (busy_cnt != '0) begin
         busy_cnt    <= busy_cnt - 1'b1;
         rsta_busy_0 <= (busy_cnt != CNT_W'(1));
      end else if (BRAM_PORTA_0_en) begin
         // Write-first: a simultaneous write is visible on dout at the same edge.
         BRAM_PORTA_0_dout <= BRAM_PORTA_0_we ? BRAM_PORTA_0_din : mem[BRAM_PORTA_0_addr];
      end
   end

   // NOTE: the storage array has no reset branch; reset must leave contents intact,
   // and a reset loop over 4096 words would prevent block-RAM inference. Power-up
   // contents come from the all-zero device configuration.
   always_ff @(posedge BRAM_PORTA_0_clk) begin
      if (accept && BRAM_PORTA_0_we) begin
         mem[BRAM_PORTA_0_addr] <= BRAM_PORTA_0_din;
      end
   end

endmodule

// File: tb/tb_bram_4096.sv
// Self-checking bench for bram_4096: directed scenarios plus a randomized run,
// all compared against a behavioural model of the RAM kept in the bench.
module tb_bram_4096;

   localparam int AW = 12;
   localparam int DW = 8;
   localparam int BC = 4;

   logic          clk  = 1'b0;
   logic          rst  = 1'b0;
   logic          en   = 1'b0;
   logic          we   = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din  = '0;
   logic [DW-1:0] dout;
   logic          busy;

   int n_cmp = 0;
   int n_bad = 0;

   // Behavioural reference: byte array, busy countdown, last read value.
   byte unsigned  ref_mem [1 << AW];
   int            ref_cnt  = 0;
   logic [DW-1:0] ref_dout = '0;

   always #5 clk = ~clk;

   bram_4096 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BUSY_CYCLES(BC)) dut (
      .BRAM_PORTA_0_clk (clk),
      .BRAM_PORTA_0_rst (rst),
      .BRAM_PORTA_0_addr(addr),
      .BRAM_PORTA_0_din (din),
      .BRAM_PORTA_0_dout(dout),
      .BRAM_PORTA_0_en  (en),
      .BRAM_PORTA_0_we  (we),
      .rsta_busy_0      (busy)
   );

   // One rising edge: the model applies the port rules to the inputs presented
   // at that edge, then outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         ref_cnt  = BC;
         ref_dout = '0;
      end else if (ref_cnt > 0) begin
         ref_cnt = ref_cnt - 1;
      end else begin
         if (we) ref_mem[addr] = din;
         if (en) ref_dout = ref_mem[addr];
      end
      #1;
   endtask

   task automatic drive(input logic r, input logic e, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
      rst = r; en = e; we = w; addr = a; din = d;
   endtask

   task automatic test_power_up();
      drive(0, 0, 0, '0, '0);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++; $display("FAIL power_up_busy: got %0b want 0", busy);
      end
      n_cmp++;
      if (dout !== 8'h00) begin
         n_bad++; $display("FAIL power_up_dout: got %02h want 00", dout);
      end
      drive(0, 1, 0, 12'd0, '0);
      tick();
      n_cmp++;
      if (dout !== 8'h00) begin
         n_bad++; $display("FAIL power_up_read0: got %02h want 00", dout);
      end
      drive(0, 1, 0, 12'd4095, '0);
      tick();
      n_cmp++;
      if (dout !== 8'h00) begin
         n_bad++; $display("FAIL power_up_read4095: got %02h want 00", dout);
      end
      drive(0, 0, 0, '0, '0);
      tick();
   endtask

   task automatic test_reset();
      int highs;
      // Single-edge reset: busy is seen high after the rst edge and the next BC-1 edges.
      drive(1, 0, 0, '0, '0);
      tick();
      drive(0, 0, 0, '0, '0);
      highs = (busy === 1'b1) ? 1 : 0;
      n_cmp++;
      if (dout !== 8'h00) begin
         n_bad++; $display("FAIL reset_dout: got %02h want 00", dout);
      end
      for (int i = 1; i <= BC + 2; i++) begin
         tick();
         if (busy === 1'b1) highs++;
         n_cmp++;
         if (busy !== (i < BC) || dout !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_window edge+%0d: busy=%0b dout=%02h want busy=%0b dout=00",
                     i, busy, dout, (i < BC));
         end
      end
      n_cmp++;
      if (highs != BC) begin
         n_bad++; $display("FAIL reset_busy_len: got %0d want %0d", highs, BC);
      end
      // Reset held for three edges: the window runs BC edges past the last rst edge.
      drive(1, 0, 0, '0, '0);
      for (int i = 0; i < 3; i++) tick();
      drive(0, 0, 0, '0, '0);
      for (int i = 1; i <= BC + 1; i++) begin
         tick();
         n_cmp++;
         if (busy !== (i < BC)) begin
            n_bad++; $display("FAIL reset_held edge+%0d: busy=%0b want %0b", i, busy, (i < BC));
         end
      end
   endtask

   task automatic test_write_no_en();
      drive(0, 0, 1, 12'd2, 8'hAA);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (dout !== 8'h00) begin
            n_bad++; $display("FAIL write_no_en_hold: got %02h want 00", dout);
         end
      end
      drive(0, 0, 0, 12'd0, 8'h00);
      tick();
      drive(0, 1, 0, 12'd2, 8'h00);
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++;
         if (dout !== 8'hAA) begin
            n_bad++; $display("FAIL write_no_en_read %0d: got %02h want AA", i, dout);
         end
      end
      drive(0, 0, 1, 12'd9, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         tick();
         addr = 12'(i * 100);
         n_cmp++;
         if (dout !== 8'hAA) begin
            n_bad++; $display("FAIL en_low_hold %0d: got %02h want AA", i, dout);
         end
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_boundaries();
      drive(0, 0, 1, 12'd4095, 8'h5C); tick();
      drive(0, 0, 1, 12'd0, 8'h3A);    tick();
      drive(0, 1, 0, 12'd4095, 8'h00); tick();
      n_cmp++;
      if (dout !== 8'h5C) begin
         n_bad++; $display("FAIL boundary_4095: got %02h want 5C", dout);
      end
      drive(0, 1, 0, 12'd0, 8'h00); tick();
      n_cmp++;
      if (dout !== 8'h3A) begin
         n_bad++; $display("FAIL boundary_0: got %02h want 3A", dout);
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_write_first();
      drive(0, 1, 1, 12'd7, 8'h81); tick();
      n_cmp++;
      if (dout !== 8'h81) begin
         n_bad++; $display("FAIL write_first_same_edge: got %02h want 81", dout);
      end
      drive(0, 1, 0, 12'd6, 8'h00); tick();
      drive(0, 1, 0, 12'd7, 8'h00); tick();
      n_cmp++;
      if (dout !== 8'h81) begin
         n_bad++; $display("FAIL write_first_readback: got %02h want 81", dout);
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_busy_window();
      // mem[2] still holds AA; a write on the rst edge itself must also be lost.
      drive(1, 1, 1, 12'd20, 8'h77); tick();
      for (int i = 0; i < BC; i++) begin
         drive(0, 1, (i < 2), 12'd2, 8'hFF);
         tick();
         n_cmp++;
         if (dout !== 8'h00) begin
            n_bad++; $display("FAIL busy_ignored %0d: got %02h want 00", i, dout);
         end
      end
      drive(0, 1, 0, 12'd2, 8'h00); tick();
      n_cmp++;
      if (busy !== 1'b0 || dout !== 8'hAA) begin
         n_bad++; $display("FAIL busy_after_read2: busy=%0b dout=%02h want busy=0 dout=AA", busy, dout);
      end
      drive(0, 1, 0, 12'd20, 8'h00); tick();
      n_cmp++;
      if (dout !== 8'h00) begin
         n_bad++; $display("FAIL reset_edge_write: got %02h want 00", dout);
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 12'(10 + i), 8'(8'h10 + i));
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 0, 12'(10 + i), 8'h00);
         tick();
         n_cmp++;
         if (dout !== 8'(8'h10 + i)) begin
            n_bad++; $display("FAIL back_to_back addr %0d: got %02h want %02h", 10 + i, dout, 8'(8'h10 + i));
         end
      end
      drive(0, 0, 0, '0, '0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15)),
               8'($urandom));
         if ($urandom_range(0, 15) == 0) addr = 12'd4095;
         tick();
         n_cmp++;
         if (dout !== ref_dout || busy !== (ref_cnt != 0)) begin
            n_bad++;
            $display("FAIL random cycle %0d: dout=%02h busy=%0b want dout=%02h busy=%0b",
                     i, dout, busy, ref_dout, (ref_cnt != 0));
         end
      end
      drive(0, 0, 0, '0, '0);
   endtask

   initial begin
      test_power_up();
      test_reset();
      test_write_no_en();
      test_boundaries();
      test_write_first();
      test_busy_window();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
